// File: rtl/ram_dma_ctrl_pkg.sv
// Shared definitions for the RAM DMA controller: register map, CTRL/STAT bit
// positions and the engine state encoding.
package nano6502_pkg;

  localparam logic [2:0] REG_SRC_L = 3'd0;
  localparam logic [2:0] REG_SRC_H = 3'd1;
  localparam logic [2:0] REG_DST_L = 3'd2;
  localparam logic [2:0] REG_DST_H = 3'd3;
  localparam logic [2:0] REG_LEN_L = 3'd4;
  localparam logic [2:0] REG_LEN_H = 3'd5;
  localparam logic [2:0] REG_FILL  = 3'd6;
  localparam logic [2:0] REG_CTRL  = 3'd7;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_FILL     = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_CLR_DONE = 6;
  localparam int unsigned STAT_DONE     = 6;
  localparam int unsigned STAT_BUSY     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_t;

endpackage

// File: rtl/ram_dma_ctrl_if.sv
// RAM-side bus of the DMA controller: the master drives the RAM port while it
// holds the grant, the slave (RAM/mux side) returns registered read data.
interface ram_dma_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              grant;
  logic              rdy;
  logic [ADDR_W-1:0] addr;
  logic              rwn;
  logic              cs;
  logic [7:0]        wdata;
  logic [7:0]        rdata;

  modport master (
    output grant, rdy, addr, rwn, cs, wdata,
    input  rdata
  );

  modport slave (
    input  grant, rdy, addr, rwn, cs, wdata,
    output rdata
  );
endinterface

// File: rtl/ram_dma_ctrl.sv
// Bus-master block copy/fill engine for main RAM. Programmed through 8 CPU
// registers; stalls the CPU and owns the RAM port while a transfer runs.
module ram_dma_ctrl
  import nano6502_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              R_W_n,
  input  logic [2:0]        reg_addr_i,
  input  logic [7:0]        data_i,
  input  logic              dma_cs,
  output logic [7:0]        data_o,
  output logic              cpu_rdy_o,
  output logic              dma_grant_o,
  output logic [ADDR_W-1:0] dma_addr_o,
  output logic              dma_rwn_o,
  output logic              dma_ram_cs_o,
  output logic [7:0]        dma_wdata_o,
  input  logic [7:0]        ram_data_i,
  output logic              irq_n_o
);

  dma_state_t        r_state;
  dma_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [7:0]        r_fill;
  logic              r_fill_mode;
  logic              r_irq_en;
  logic              r_done;

  logic              w_busy;
  logic              w_reg_wr;
  logic              w_ctrl_wr;
  logic              w_start;
  logic              w_len_zero;
  logic              w_last;
  logic [15:0]       w_src16;
  logic [15:0]       w_dst16;
  logic [15:0]       w_len16;
  logic [7:0]        w_stat;

  assign w_busy     = (r_state != IDLE);
  // Register writes are only honoured in IDLE, which also makes start-while-busy a no-op.
  assign w_reg_wr   = dma_cs & ~R_W_n & ~w_busy;
  assign w_ctrl_wr  = w_reg_wr & (reg_addr_i == REG_CTRL);
  assign w_start    = w_ctrl_wr & data_i[CTRL_START];
  assign w_len_zero = (r_len == '0);
  assign w_last     = (r_len == LEN_W'(1));

  assign w_src16 = 16'(r_src);
  assign w_dst16 = 16'(r_dst);
  assign w_len16 = 16'(r_len);
  assign w_stat  = {w_busy, r_done, 3'b000, r_irq_en, r_fill_mode, 1'b0};

  always_comb begin
    data_o = '0;
    unique case (reg_addr_i)
      REG_SRC_L: data_o = w_src16[7:0];
      REG_SRC_H: data_o = w_src16[15:8];
      REG_DST_L: data_o = w_dst16[7:0];
      REG_DST_H: data_o = w_dst16[15:8];
      REG_LEN_L: data_o = w_len16[7:0];
      REG_LEN_H: data_o = w_len16[15:8];
      REG_FILL:  data_o = r_fill;
      REG_CTRL:  data_o = w_stat;
      default:   data_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The copy/fill decision at start uses the mode bit being written, not the stored one.
  always_comb begin
    w_state_nxt  = r_state;
    dma_addr_o   = '0;
    dma_rwn_o    = 1'b1;
    dma_ram_cs_o = 1'b0;
    dma_wdata_o  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_start && !w_len_zero) begin
          w_state_nxt = data_i[CTRL_FILL] ? WR : RD;
        end
      end
      RD: begin
        dma_addr_o   = r_src;
        dma_rwn_o    = 1'b1;
        dma_ram_cs_o = 1'b1;
        w_state_nxt  = WR;
      end
      WR: begin
        dma_addr_o   = r_dst;
        dma_rwn_o    = 1'b0;
        dma_ram_cs_o = 1'b1;
        dma_wdata_o  = r_fill_mode ? r_fill : ram_data_i;
        if (w_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = r_fill_mode ? WR : RD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_fill      <= '0;
      r_fill_mode <= 1'b0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_reg_wr) begin
        unique case (reg_addr_i)
          REG_SRC_L: r_src <= {r_src[ADDR_W-1:8], data_i};
          REG_SRC_H: r_src <= {data_i[ADDR_W-9:0], r_src[7:0]};
          REG_DST_L: r_dst <= {r_dst[ADDR_W-1:8], data_i};
          REG_DST_H: r_dst <= {data_i[ADDR_W-9:0], r_dst[7:0]};
          REG_LEN_L: r_len <= {r_len[LEN_W-1:8], data_i};
          REG_LEN_H: r_len <= {data_i[LEN_W-9:0], r_len[7:0]};
          REG_FILL:  r_fill <= data_i;
          REG_CTRL: begin
            r_fill_mode <= data_i[CTRL_FILL];
            r_irq_en    <= data_i[CTRL_IRQ_EN];
            // Clear is evaluated before a zero-length start so the latter wins.
            if (data_i[CTRL_CLR_DONE]) begin
              r_done <= 1'b0;
            end
            if (data_i[CTRL_START] && w_len_zero) begin
              r_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (r_state == WR) begin
        if (!r_fill_mode) begin
          r_src <= r_src + ADDR_W'(1);
        end
        r_dst <= r_dst + ADDR_W'(1);
        r_len <= r_len - LEN_W'(1);
        if (w_last) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign cpu_rdy_o   = ~w_busy;
  assign dma_grant_o = w_busy;
  assign irq_n_o     = ~(r_done & r_irq_en);

endmodule

// File: tb/tb_ram_dma_ctrl.sv
// Directed bench for ram_dma_ctrl: register table plus copy, fill, zero-length,
// wrap, interrupt and mid-transfer reset sequences against a RAM model.
module tb_ram_dma_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       R_W_n = 1'b1;
  logic [2:0] reg_addr = '0;
  logic [7:0] wdat = '0;
  logic       cs = 1'b0;
  logic [7:0] rdat;
  logic       irq_n;

  ram_dma_ctrl_if #(.ADDR_W(16)) bus ();

  ram_dma_ctrl #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .R_W_n        (R_W_n),
    .reg_addr_i   (reg_addr),
    .data_i       (wdat),
    .dma_cs       (cs),
    .data_o       (rdat),
    .cpu_rdy_o    (bus.rdy),
    .dma_grant_o  (bus.grant),
    .dma_addr_o   (bus.addr),
    .dma_rwn_o    (bus.rwn),
    .dma_ram_cs_o (bus.cs),
    .dma_wdata_o  (bus.wdata),
    .ram_data_i   (bus.rdata),
    .irq_n_o      (irq_n)
  );

  always #5 clk = ~clk;

  // RAM model with registered read; bench preloads go through the same process.
  logic [7:0]  mem [0:65535];
  logic [15:0] rd_log [0:1023];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus.cs && !bus.rwn) begin
      mem[bus.addr] <= bus.wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.cs && bus.rwn) begin
      bus.rdata <= mem[bus.addr];
      rd_log[rd_cnt[9:0]] <= bus.addr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; R_W_n = 1'b0; reg_addr = a; wdat = d;
    @(negedge clk);
    cs = 1'b0; R_W_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    reg_addr = a;
    #1 d = rdat;
  endtask

  task automatic set_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    cpu_write(3'd0, s[7:0]); cpu_write(3'd1, s[15:8]);
    cpu_write(3'd2, d[7:0]); cpu_write(3'd3, d[15:8]);
    cpu_write(3'd4, l[7:0]); cpu_write(3'd5, l[15:8]);
  endtask

  task automatic wait_idle(input int bound, output int cyc);
    cyc = 0;
    while (bus.grant && cyc < bound) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= bound) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: still busy after %0d cycles", bound);
    end
  endtask

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [7:0] r;
    int cyc, rb, wb, bad;
    logic [15:0] wrap_exp [4];
    logic [7:0]  cp [4];

    vt[0] = '{3'd0, 8'h34, 8'h34};
    vt[1] = '{3'd1, 8'h12, 8'h12};
    vt[2] = '{3'd2, 8'h78, 8'h78};
    vt[3] = '{3'd3, 8'h56, 8'h56};
    vt[4] = '{3'd4, 8'hBC, 8'hBC};
    vt[5] = '{3'd5, 8'h9A, 8'h9A};
    vt[6] = '{3'd6, 8'hA5, 8'hA5};
    vt[7] = '{3'd7, 8'h06, 8'h06};
    vt[8] = '{3'd7, 8'hF2, 8'h02};
    vt[9] = '{3'd7, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy", bus.rdy, 1);
    check("rst_grant", bus.grant, 0);
    check("rst_ramcs", bus.cs, 0);
    check("rst_rwn", bus.rwn, 1);
    check("rst_addr", bus.addr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_irq_n", irq_n, 1);
    for (int i = 0; i < 8; i++) begin
      cpu_read(3'(i), r);
      check($sformatf("rst_reg%0d", i), r, 0);
    end

    for (int i = 0; i < 10; i++) begin
      cpu_write(vt[i].a, vt[i].d);
      cpu_read(vt[i].a, r);
      check($sformatf("vec%0d_reg%0d", i, vt[i].a), r, vt[i].e);
    end

    // Copy 4 bytes
    cp[0] = 8'h11; cp[1] = 8'h22; cp[2] = 8'h33; cp[3] = 8'h44;
    for (int i = 0; i < 4; i++) poke(16'h1000 + 16'(i), cp[i]);
    set_xfer(16'h1000, 16'h2000, 16'd4);
    rb = rd_cnt; wb = wr_cnt;
    cpu_write(3'd7, 8'h01);
    check("copy_rdy_busy", bus.rdy, 0);
    check("copy_grant_busy", bus.grant, 1);
    wait_idle(100, cyc);
    check("copy_cycles", cyc, 8);
    check("copy_reads", rd_cnt - rb, 4);
    check("copy_writes", wr_cnt - wb, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("copy_mem%0d", i), mem[16'h2000 + 16'(i)], cp[i]);
    cpu_read(3'd0, r); check("copy_src_l", r, 8'h04);
    cpu_read(3'd1, r); check("copy_src_h", r, 8'h10);
    cpu_read(3'd2, r); check("copy_dst_l", r, 8'h04);
    cpu_read(3'd3, r); check("copy_dst_h", r, 8'h20);
    cpu_read(3'd4, r); check("copy_len_l", r, 8'h00);
    cpu_read(3'd5, r); check("copy_len_h", r, 8'h00);
    cpu_read(3'd7, r); check("copy_stat", r, 8'h40);

    // Fill 256 bytes
    cpu_write(3'd7, 8'h40);
    set_xfer(16'h0000, 16'h0300, 16'h0100);
    cpu_write(3'd6, 8'hAA);
    poke(16'h0400, 8'h55);
    rb = rd_cnt; wb = wr_cnt;
    cpu_write(3'd7, 8'h03);
    wait_idle(1000, cyc);
    check("fill_cycles", cyc, 256);
    check("fill_reads", rd_cnt - rb, 0);
    check("fill_writes", wr_cnt - wb, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[16'h0300 + 16'(i)] !== 8'hAA) bad++;
    check("fill_bad_bytes", bad, 0);
    check("fill_guard", mem[16'h0400], 8'h55);
    cpu_read(3'd7, r); check("fill_stat", r, 8'h42);
    cpu_read(3'd3, r); check("fill_dst_h", r, 8'h04);

    // Zero-length start
    cpu_write(3'd7, 8'h40);
    cpu_read(3'd7, r); check("len0_stat_clr", r, 8'h00);
    rb = rd_cnt; wb = wr_cnt;
    cpu_write(3'd7, 8'h01);
    check("len0_rdy", bus.rdy, 1);
    check("len0_grant", bus.grant, 0);
    cpu_read(3'd7, r); check("len0_stat", r, 8'h40);
    @(negedge clk);
    check("len0_no_ram", (rd_cnt - rb) + (wr_cnt - wb), 0);

    // Address wrap, plus a register write attempted while busy
    cpu_write(3'd7, 8'h40);
    set_xfer(16'hFFFE, 16'h6000, 16'd4);
    cpu_write(3'd6, 8'h5A);
    rb = rd_cnt;
    cpu_write(3'd7, 8'h01);
    cpu_write(3'd6, 8'h77);
    wait_idle(100, cyc);
    wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF;
    wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;
    check("wrap_reads", rd_cnt - rb, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap_rd%0d", i), rd_log[10'(rb + i)], wrap_exp[i]);
    cpu_read(3'd0, r); check("wrap_src_l", r, 8'h02);
    cpu_read(3'd1, r); check("wrap_src_h", r, 8'h00);
    cpu_read(3'd6, r); check("busy_wr_ignored", r, 8'h5A);

    // Interrupt
    cpu_write(3'd7, 8'h40);
    set_xfer(16'h1000, 16'h7000, 16'd2);
    check("irq_idle", irq_n, 1);
    cpu_write(3'd7, 8'h05);
    check("irq_busy", irq_n, 1);
    wait_idle(100, cyc);
    check("irq_cycles", cyc, 4);
    check("irq_done", irq_n, 0);
    cpu_write(3'd7, 8'h40);
    check("irq_cleared", irq_n, 1);

    // Reset after 3 of 10 bytes
    for (int i = 0; i < 10; i++) poke(16'h4000 + 16'(i), 8'(i + 1));
    poke(16'h5003, 8'hEE);
    set_xfer(16'h4000, 16'h5000, 16'd10);
    wb = wr_cnt;
    cpu_write(3'd7, 8'h05);
    cyc = 0;
    while ((wr_cnt - wb) < 3 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("rst_mid_progress", wr_cnt - wb, 3);
    rst = 1'b1;
    @(negedge clk);
    check("rstm_grant", bus.grant, 0);
    check("rstm_rdy", bus.rdy, 1);
    check("rstm_ramcs", bus.cs, 0);
    check("rstm_irq_n", irq_n, 1);
    for (int i = 0; i < 8; i++) begin
      cpu_read(3'(i), r);
      check($sformatf("rstm_reg%0d", i), r, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("rstm_mem%0d", i), mem[16'h5000 + 16'(i)], 8'(i + 1));
    check("rstm_mem3_untouched", mem[16'h5003], 8'hEE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
